control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 40 ++++
 rtl/control_unit_tad_validator.sv | 51 +++++
 rtl/control_unit.sv | 73 +++++++
 tb/tb_control_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the clock control unit: time/date word layout,
// FSM state constants and a BCD helper used by the frame validator.
package control_unit_pkg;

    localparam int TAD_W = 44;

    // Field positions inside the 44-bit BCD time/date word
    localparam int SEC_LO_LSB  = 0;   localparam int SEC_LO_W  = 4;
    localparam int SEC_HI_LSB  = 4;   localparam int SEC_HI_W  = 3;
    localparam int MIN_LO_LSB  = 7;   localparam int MIN_LO_W  = 4;
    localparam int MIN_HI_LSB  = 11;  localparam int MIN_HI_W  = 3;
    localparam int HOUR_LO_LSB = 14;  localparam int HOUR_LO_W = 4;
    localparam int HOUR_HI_LSB = 18;  localparam int HOUR_HI_W = 2;
    localparam int DAY_LO_LSB  = 20;  localparam int DAY_LO_W  = 4;
    localparam int DAY_HI_LSB  = 24;  localparam int DAY_HI_W  = 2;
    localparam int MON_LO_LSB  = 26;  localparam int MON_LO_W  = 4;
    localparam int MON_HI_LSB  = 30;  localparam int MON_HI_W  = 1;
    localparam int YEAR_LO_LSB = 31;  localparam int YEAR_LO_W = 4;
    localparam int YEAR_HI_LSB = 35;  localparam int YEAR_HI_W = 4;
    localparam int WDAY_LSB    = 39;  localparam int WDAY_W    = 3;
    localparam int TZ_LSB      = 42;  localparam int TZ_W      = 2;

    // FSM encoding; the enum gives the same values a readable type
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_SET      = 2'd1;
    localparam logic [1:0] ST_DCF_LOAD = 2'd2;

    typedef enum logic [1:0] {
        RUN      = ST_RUN,
        SET      = ST_SET,
        DCF_LOAD = ST_DCF_LOAD
    } state_e;

    // Two BCD digits to binary; digits above 9 still give a (large) value,
    // which the range checks then reject.
    function automatic logic [7:0] bcd_val(input logic [3:0] hi, input logic [3:0] lo);
        return 8'(hi) * 8'd10 + 8'(lo);
    endfunction

endpackage

// File: rtl/control_unit_tad_validator.sv
// Combinational plausibility check of a decoded DCF77 time/date word.
// Timezone bits are accepted as-is.
module tad_validator
    import control_unit_pkg::*;
(
    input  logic [TAD_W-1:0] tad,
    output logic             valid
);

    logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hour_lo, hour_hi;
    logic [3:0] day_lo, day_hi, mon_lo, mon_hi, year_lo, year_hi;
    logic [2:0] wday;
    logic [7:0] sec, min, hour, day, mon;
    logic       digits_ok, ranges_ok;
    logic       unused_tz;

    assign sec_lo  = 4'(tad[SEC_LO_LSB  +: SEC_LO_W]);
    assign sec_hi  = 4'(tad[SEC_HI_LSB  +: SEC_HI_W]);
    assign min_lo  = 4'(tad[MIN_LO_LSB  +: MIN_LO_W]);
    assign min_hi  = 4'(tad[MIN_HI_LSB  +: MIN_HI_W]);
    assign hour_lo = 4'(tad[HOUR_LO_LSB +: HOUR_LO_W]);
    assign hour_hi = 4'(tad[HOUR_HI_LSB +: HOUR_HI_W]);
    assign day_lo  = 4'(tad[DAY_LO_LSB  +: DAY_LO_W]);
    assign day_hi  = 4'(tad[DAY_HI_LSB  +: DAY_HI_W]);
    assign mon_lo  = 4'(tad[MON_LO_LSB  +: MON_LO_W]);
    assign mon_hi  = 4'(tad[MON_HI_LSB  +: MON_HI_W]);
    assign year_lo = 4'(tad[YEAR_LO_LSB +: YEAR_LO_W]);
    assign year_hi = 4'(tad[YEAR_HI_LSB +: YEAR_HI_W]);
    assign wday    = tad[WDAY_LSB +: WDAY_W];
    assign unused_tz = ^tad[TZ_LSB +: TZ_W];

    assign sec  = bcd_val(sec_hi,  sec_lo);
    assign min  = bcd_val(min_hi,  min_lo);
    assign hour = bcd_val(hour_hi, hour_lo);
    assign day  = bcd_val(day_hi,  day_lo);
    assign mon  = bcd_val(mon_hi,  mon_lo);

    // Only the 4-bit digits can exceed 9 on their own; narrower tens digits
    // are bounded by the field range checks below.
    assign digits_ok = (sec_lo  <= 4'd9) && (min_lo  <= 4'd9) && (hour_lo <= 4'd9) &&
                       (day_lo  <= 4'd9) && (mon_lo  <= 4'd9) && (year_lo <= 4'd9) &&
                       (year_hi <= 4'd9);

    assign ranges_ok = (sec  <= 8'd59) && (min <= 8'd59) && (hour <= 8'd23) &&
                       (day  >= 8'd1)  && (day <= 8'd31) &&
                       (mon  >= 8'd1)  && (mon <= 8'd12) &&
                       (wday != 3'd0);

    assign valid = digits_ok && ranges_ok;

endmodule

// File: rtl/control_unit.sv
// Clock control unit: selects what the display shows and when the running
// clock is (re)loaded, either from the manual set unit or from DCF77.
module control_unit
    import control_unit_pkg::*;
(
    input  logic             cll,
    input  logic             nReset,
    input  logic             clk_en,
    input  logic             SET_in,
    input  logic             DCF_Enable_in,
    input  logic             DCF_set_in,
    input  logic [TAD_W-1:0] DCF_timeAndDate_in,
    input  logic [TAD_W-1:0] SetClock_timeAndDate_in,
    input  logic [TAD_W-1:0] clock_timeAndDate_In,
    output logic [TAD_W-1:0] LCD_timeAndDate_Out,
    output logic [TAD_W-1:0] clock_timeAndDate_Out,
    output logic             clock_set_out
);

    logic [1:0] state, state_nxt;
    logic       dcf_valid;
    logic       dcf_take;

    tad_validator u_validator (
        .tad   (DCF_timeAndDate_in),
        .valid (dcf_valid)
    );

    // A DCF frame is only taken from RUN, so a held strobe yields one load
    // per RUN/DCF_LOAD round trip; SET_in always wins.
    assign dcf_take = (state == ST_RUN) && !SET_in && DCF_Enable_in &&
                      DCF_set_in && dcf_valid;

    // Next-state selection
    always_comb begin
        state_nxt = ST_RUN;
        case (state)
            ST_RUN:      state_nxt = SET_in ? ST_SET : (dcf_take ? ST_DCF_LOAD : ST_RUN);
            ST_SET:      state_nxt = SET_in ? ST_SET : ST_RUN;
            ST_DCF_LOAD: state_nxt = SET_in ? ST_SET : ST_RUN;
            default:     state_nxt = ST_RUN;
        endcase
    end

    // State and registered outputs, advanced only on enabled edges
    always_ff @(posedge cll or negedge nReset) begin
        if (!nReset) begin
            state                 <= ST_RUN;
            LCD_timeAndDate_Out   <= '0;
            clock_timeAndDate_Out <= '0;
            clock_set_out         <= 1'b0;
        end else if (clk_en) begin
            state <= state_nxt;
            case (state_nxt)
                ST_SET: begin
                    LCD_timeAndDate_Out   <= SetClock_timeAndDate_in;
                    clock_timeAndDate_Out <= SetClock_timeAndDate_in;
                    clock_set_out         <= 1'b1;
                end
                ST_DCF_LOAD: begin
                    LCD_timeAndDate_Out   <= DCF_timeAndDate_in;
                    clock_timeAndDate_Out <= DCF_timeAndDate_in;
                    clock_set_out         <= 1'b1;
                end
                default: begin
                    LCD_timeAndDate_Out   <= clock_timeAndDate_In;
                    clock_set_out         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed frame table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_control_unit;

    logic        cll = 1'b0;
    logic        nReset;
    logic        clk_en;
    logic        SET_in;
    logic        DCF_Enable_in;
    logic        DCF_set_in;
    logic [43:0] dcf, sc, ci;
    logic [43:0] lcd, co;
    logic        cs;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: 0 = running, 1 = manual set, 2 = DCF load pulse
    int          m_mode;
    logic [43:0] m_lcd, m_co;
    logic        m_cs;

    typedef struct {
        string       name;
        logic [43:0] frame;
        logic        ok;
    } vec_t;
    vec_t tbl[$];

    control_unit dut (
        .cll                     (cll),
        .nReset                  (nReset),
        .clk_en                  (clk_en),
        .SET_in                  (SET_in),
        .DCF_Enable_in           (DCF_Enable_in),
        .DCF_set_in              (DCF_set_in),
        .DCF_timeAndDate_in      (dcf),
        .SetClock_timeAndDate_in (sc),
        .clock_timeAndDate_In    (ci),
        .LCD_timeAndDate_Out     (lcd),
        .clock_timeAndDate_Out   (co),
        .clock_set_out           (cs)
    );

    always #5 cll = ~cll;

    function automatic logic [43:0] pack(input int s, input int mi, input int h, input int d,
                                         input int mo, input int y, input int wd, input int tz);
        logic [43:0] t;
        t = '0;
        t[3:0]   = 4'(s % 10);   t[6:4]   = 3'(s / 10);
        t[10:7]  = 4'(mi % 10);  t[13:11] = 3'(mi / 10);
        t[17:14] = 4'(h % 10);   t[19:18] = 2'(h / 10);
        t[23:20] = 4'(d % 10);   t[25:24] = 2'(d / 10);
        t[29:26] = 4'(mo % 10);  t[30]    = 1'(mo / 10);
        t[34:31] = 4'(y % 10);   t[38:35] = 4'(y / 10);
        t[41:39] = 3'(wd);       t[43:42] = 2'(tz);
        return t;
    endfunction

    function automatic logic [43:0] rand_raw();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[43:0];
    endfunction

    function automatic logic [43:0] rand_valid();
        return pack($urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(0, 23),
                    $urandom_range(1, 31), $urandom_range(1, 12), $urandom_range(0, 99),
                    $urandom_range(1, 7), $urandom_range(0, 3));
    endfunction

    // Decode the word to decimal numbers and apply calendar limits
    function automatic bit ref_valid(input logic [43:0] t);
        int sl = int'(t[3:0]),   sh = int'(t[6:4]);
        int ml = int'(t[10:7]),  mh = int'(t[13:11]);
        int hl = int'(t[17:14]), hh = int'(t[19:18]);
        int dl = int'(t[23:20]), dh = int'(t[25:24]);
        int ol = int'(t[29:26]), oh = int'(t[30]);
        int yl = int'(t[34:31]), yh = int'(t[38:35]);
        int wd = int'(t[41:39]);
        if (sl > 9 || ml > 9 || hl > 9 || dl > 9 || ol > 9 || yl > 9 || yh > 9) return 0;
        if (sh * 10 + sl > 59) return 0;
        if (mh * 10 + ml > 59) return 0;
        if (hh * 10 + hl > 23) return 0;
        if (dh * 10 + dl < 1 || dh * 10 + dl > 31) return 0;
        if (oh * 10 + ol < 1 || oh * 10 + ol > 12) return 0;
        return (wd >= 1 && wd <= 7);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_lcd = '0; m_co = '0; m_cs = 1'b0;
    endtask

    // Manual set overrides everything; a good DCF frame is only taken while
    // running; otherwise the display follows the clock and the strobe drops.
    task automatic model_edge();
        if (!nReset) model_reset();
        else if (clk_en) begin
            if (SET_in) begin
                m_mode = 1; m_lcd = sc; m_co = sc; m_cs = 1'b1;
            end else if (m_mode == 0 && DCF_Enable_in && DCF_set_in && ref_valid(dcf)) begin
                m_mode = 2; m_lcd = dcf; m_co = dcf; m_cs = 1'b1;
            end else begin
                m_mode = 0; m_lcd = ci; m_cs = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge cll);
        model_edge();
        @(negedge cll);
    endtask

    task automatic chk(input string nm, input logic [43:0] act, input logic [43:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " lcd"}, lcd, m_lcd);
        chk({tag, " clock_out"}, co, m_co);
        chk({tag, " set_out"}, 44'(cs), 44'(m_cs));
    endtask

    logic [43:0] dcf_a, dcf_b, dcf_bad, sc_a, sc_b, ci_b, base, t;

    initial begin
        nReset = 1'b0; clk_en = 1'b1; SET_in = 1'b0; DCF_Enable_in = 1'b0; DCF_set_in = 1'b0;
        dcf = '0; sc = '0; ci = '0;
        model_reset();

        // frame table: boundary values of every checked field
        tbl.push_back('{"max", pack(59, 59, 23, 31, 12, 99, 7, 3), 1'b1});
        tbl.push_back('{"min", pack(0, 0, 0, 1, 1, 0, 1, 0), 1'b1});
        tbl.push_back('{"sec60", pack(60, 0, 12, 15, 6, 20, 3, 0), 1'b0});
        tbl.push_back('{"min60", pack(0, 60, 12, 15, 6, 20, 3, 0), 1'b0});
        tbl.push_back('{"hour24", pack(0, 0, 24, 15, 6, 20, 3, 0), 1'b0});
        tbl.push_back('{"day0", pack(0, 0, 12, 0, 6, 20, 3, 0), 1'b0});
        tbl.push_back('{"day32", pack(0, 0, 12, 32, 6, 20, 3, 0), 1'b0});
        tbl.push_back('{"month0", pack(0, 0, 12, 15, 0, 20, 3, 0), 1'b0});
        tbl.push_back('{"month13", pack(0, 0, 12, 15, 13, 20, 3, 0), 1'b0});
        tbl.push_back('{"wday0", pack(0, 0, 12, 15, 6, 20, 0, 0), 1'b0});
        t = pack(10, 0, 12, 15, 6, 20, 3, 0); t[3:0] = 4'hA;
        tbl.push_back('{"seclo_A", t, 1'b0});
        t = pack(10, 0, 12, 15, 6, 20, 3, 0); t[38:35] = 4'hA;
        tbl.push_back('{"yearhi_A", t, 1'b0});
        t = pack(10, 0, 12, 15, 6, 20, 3, 0); t[17:14] = 4'hB;
        tbl.push_back('{"hourlo_B", t, 1'b0});

        // reset values, no edge needed
        #1;
        chk("reset lcd", lcd, '0);
        chk("reset clock_out", co, '0);
        chk("reset set_out", 44'(cs), 44'(0));
        @(negedge cll);
        nReset = 1'b1;

        // running: display follows the clock, no load
        ci = pack(45, 59, 23, 31, 7, 19, 2, 0);
        tick();
        chk("run lcd", lcd, ci);
        chk("run set_out", 44'(cs), 44'(0));
        chk("run clock_out", co, '0);

        // single DCF strobe -> one-cycle load pulse
        dcf_a = pack(21, 59, 23, 23, 6, 19, 2, 1);
        dcf = dcf_a; DCF_Enable_in = 1'b1; DCF_set_in = 1'b1;
        tick();
        chk("dcf clock_out", co, dcf_a);
        chk("dcf set_out", 44'(cs), 44'(1));
        chk("dcf lcd", lcd, dcf_a);
        DCF_set_in = 1'b0;
        tick();
        chk("dcf pulse end", 44'(cs), 44'(0));
        chk("dcf clock_out hold", co, dcf_a);
        chk("dcf lcd back", lcd, ci);

        // invalid frame and disabled DCF are both ignored
        dcf_bad = dcf_a; dcf_bad[3:0] = 4'hA;
        dcf = dcf_bad; DCF_set_in = 1'b1;
        tick();
        chk("bad dcf set_out", 44'(cs), 44'(0));
        chk("bad dcf clock_out", co, dcf_a);
        dcf_b = pack(0, 30, 8, 1, 1, 20, 3, 0);
        dcf = dcf_b; DCF_Enable_in = 1'b0;
        tick();
        chk("dcf disabled set_out", 44'(cs), 44'(0));
        chk("dcf disabled clock_out", co, dcf_a);

        // held strobe: pulse every second enabled cycle
        DCF_Enable_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("held strobe %0d", i), 44'(cs), 44'((i % 2) == 0));
        end
        DCF_set_in = 1'b0;
        tick();

        // manual set with a simultaneous DCF strobe
        sc_a = pack(57, 59, 23, 31, 6, 19, 5, 0);
        sc = sc_a; SET_in = 1'b1; dcf = dcf_a; DCF_set_in = 1'b1;
        tick();
        chk("set lcd", lcd, sc_a);
        chk("set clock_out", co, sc_a);
        chk("set set_out", 44'(cs), 44'(1));
        tick();
        chk("set hold set_out", 44'(cs), 44'(1));
        chk("set hold clock_out", co, sc_a);
        SET_in = 1'b0; DCF_set_in = 1'b0;
        tick();
        chk("set exit set_out", 44'(cs), 44'(0));
        chk("set exit clock_out", co, sc_a);
        chk("set exit lcd", lcd, ci);

        // clk_en low freezes a SET state
        SET_in = 1'b1;
        tick();
        clk_en = 1'b0; SET_in = 1'b0;
        sc_b = pack(1, 2, 3, 4, 5, 6, 7, 0); sc = sc_b;
        ci_b = pack(10, 20, 10, 10, 10, 10, 4, 0); ci = ci_b;
        for (int i = 0; i < 3; i++) tick();
        chk("freeze set_out", 44'(cs), 44'(1));
        chk("freeze lcd", lcd, sc_a);
        chk("freeze clock_out", co, sc_a);
        clk_en = 1'b1;
        tick();
        chk("unfreeze set_out", 44'(cs), 44'(0));
        chk("unfreeze lcd", lcd, ci_b);

        // clk_en low stretches the DCF pulse
        dcf = dcf_a; DCF_set_in = 1'b1;
        tick();
        clk_en = 1'b0; DCF_set_in = 1'b0;
        tick(); tick();
        chk("frozen pulse", 44'(cs), 44'(1));
        clk_en = 1'b1;
        tick();
        chk("frozen pulse end", 44'(cs), 44'(0));

        // asynchronous reset in the middle of SET
        SET_in = 1'b1; sc = sc_a;
        tick();
        nReset = 1'b0;
        model_reset();
        #1;
        chk("async rst lcd", lcd, '0);
        chk("async rst clock_out", co, '0);
        chk("async rst set_out", 44'(cs), 44'(0));
        #1 nReset = 1'b1;
        SET_in = 1'b0;
        tick();
        chk("post rst lcd", lcd, ci);
        chk("post rst set_out", 44'(cs), 44'(0));
        chk("post rst clock_out", co, '0);

        // frame table through the full DCF path
        base = pack(0, 0, 0, 1, 1, 0, 1, 0);
        foreach (tbl[i]) begin
            SET_in = 1'b1; sc = pack(33, 33, 11, 11, 11, 11, 6, 2); DCF_set_in = 1'b0;
            tick();
            sc = base;
            tick();
            SET_in = 1'b0;
            tick();
            dcf = tbl[i].frame; DCF_Enable_in = 1'b1; DCF_set_in = 1'b1;
            tick();
            chk({"tbl ", tbl[i].name, " set_out"}, 44'(cs), 44'(tbl[i].ok));
            chk({"tbl ", tbl[i].name, " clock_out"}, co, tbl[i].ok ? tbl[i].frame : base);
            DCF_set_in = 1'b0;
            tick();
        end

        // randomized run against the model
        for (int n = 0; n < 2000; n++) begin
            clk_en        = ($urandom % 4) != 0;
            if (($urandom % 8) == 0) SET_in = ~SET_in;
            DCF_Enable_in = ($urandom % 4) != 0;
            DCF_set_in    = ($urandom % 3) == 0;
            dcf = ($urandom % 2) ? rand_valid() : rand_raw();
            sc  = rand_raw();
            ci  = rand_valid();
            if (($urandom % 150) == 0) begin
                nReset = 1'b0;
                model_reset();
                #1;
                chk_model("rand rst");
                #1 nReset = 1'b1;
            end
            tick();
            chk_model($sformatf("rand %0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
